wb_retire_buffer: RTL and testbench
===================================

# wb_retire_buffer

Parametrised writeback stage for the RISC CPU pipeline. It selects the result to retire (ALU result, sized and extended load data, N xor V flag, or link address), queues retiring writes in a DEPTH-entry in-order buffer, and drains one write per cycle into the register file whenever the file's write port is granted. Pending writes are exposed through a bypass lookup port so decode and operand fetch can forward values that are not yet in the register file.

## Interface
- WIDTH, 32: datapath width; must be at least 32.
- AW, 5: register address width.
- DEPTH, 4: retire buffer entries; must be at least 2.
- ZERO_REG, 1: when 1, writes to register 0 are discarded.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  a retiring instruction is presented.
- in_ready  out  1  buffer can accept; in_ready = (count != DEPTH).
- f_out  in  WIDTH  ALU/function unit result.
- mem_data  in  WIDTH  raw memory read word.
- addr_lo  in  2  low byte-address bits of the load.
- size  in  2  load size: 00 byte, 01 half, 10 word; 11 is treated as word.
- ld_signed  in  1  sign-extend byte/half loads when 1.
- n_xor_v  in  1  set-less-than flag.
- link  in  WIDTH  return address.
- md  in  2  result select: 00 f_out, 01 load, 10 {0, n_xor_v}, 11 link.
- da  in  AW  destination register.
- rw  in  1  register write requested.
- rf_ready  in  1  register-file write port granted this cycle.
- wr_data  out  WIDTH  registered write data.
- wr_reg  out  AW  registered write address.
- wr_en  out  1  registered write strobe; high for exactly one cycle per retired write.
- lookup_reg  in  AW  bypass query address.
- byp_hit  out  1  combinational; a pending write to lookup_reg exists.
- byp_data  out  WIDTH  combinational; data of the youngest matching pending write.
- count  out  log2(DEPTH)+1  number of occupied entries.

## Operation
- Accept: when in_valid && in_ready, the instruction is consumed. It is stored only if rw=1 and not (ZERO_REG && da==0); otherwise it is consumed with no effect.
- Result select is combinational on the inputs and is captured at push time.
- Load extraction for md=01:
  - byte: lane = mem_data[8*addr_lo +: 8].
  - half: lane = mem_data[16*addr_lo[1] +: 16]; addr_lo[0] is ignored.
  - word: low 32 bits.
  - The lane is zero- or sign-extended to WIDTH according to ld_signed. Bits above 32 of mem_data are ignored.
- Drain: each cycle with count>0 and rf_ready=1, the head entry is popped into wr_data/wr_reg with wr_en<=1. Otherwise wr_en<=0; wr_data and wr_reg hold their last values.
- The buffer is a circular FIFO with head/tail pointers that wrap modulo DEPTH. Push and pop in the same cycle leave count unchanged.
- Bypass: byp_hit/byp_data search all valid buffer entries plus the output register (when wr_en=1). The youngest match wins; the output register has the lowest priority. With no match, byp_hit=0 and byp_data=0.
- Reset values: in_ready=0 while reset is asserted and 1 after release; wr_en=0, wr_data=0, wr_reg=0, count=0, byp_hit=0. All buffered entries are discarded, including on a reset asserted mid-drain.

## Timing
- Latency:
  - Push at edge N with the buffer empty and rf_ready=1 during cycle N+1 gives wr_en=1 after edge N+1.
  - Minimum latency is 2 edges; throughput is 1 write per cycle.
- in_ready depends only on registered count. A full buffer refuses input even if a pop occurs in the same cycle.
- A stall (rf_ready=0) holds the head entry; nothing is lost or reordered.
- An entry is visible on bypass from the edge after its push until the edge after it leaves the output register.

## Test plan
- Reset, then push f_out=0x12345678, da=3, rw=1, md=00 with rf_ready=1 -> wr_en pulses once, two edges after the push, with wr_reg=3 and wr_data=0x12345678.
- Loads from mem_data=0x80FF7F01:
  - byte, addr_lo=2, signed -> 0xFFFFFFFF.
  - byte, addr_lo=0, unsigned -> 0x00000001.
  - half, addr_lo=2, signed -> 0xFFFF80FF.
  - md=10 with n_xor_v=1 -> 0x00000001.
- Hold rf_ready=0 and push DEPTH writes -> count=DEPTH, in_ready=0, a further in_valid is not consumed. Release rf_ready -> DEPTH consecutive wr_en pulses in push order, with pointers wrapping correctly.
- Drop cases: push da=0 and push rw=0 -> both consumed, count stays 0, no wr_en.
- Bypass: with rf_ready=0, push r5=0xA then r5=0xB -> lookup_reg=5 gives byp_hit=1, byp_data=0xB; lookup_reg=6 gives byp_hit=0.
- Reset asserted asynchronously mid-cycle with 3 entries pending -> outputs and count clear immediately, and no wr_en follows release.

Source files
------------

// File: rtl/wb_retire_buffer.sv
// Writeback stage: selects the retiring result, queues register writes in an in-order
// circular buffer and drains one per granted cycle, with youngest-first bypass lookup.
module wb_retire_buffer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WIDTH-1:0]         f_out_i,
  input  logic [WIDTH-1:0]         mem_data_i,
  input  logic [1:0]               addr_lo_i,
  input  logic [1:0]               size_i,
  input  logic                     ld_signed_i,
  input  logic                     n_xor_v_i,
  input  logic [WIDTH-1:0]         link_i,
  input  logic [1:0]               md_i,
  input  logic [AW-1:0]            da_i,
  input  logic                     rw_i,
  input  logic                     rf_ready_i,
  output logic [WIDTH-1:0]         wr_data_o,
  output logic [AW-1:0]            wr_reg_o,
  output logic                     wr_en_o,
  input  logic [AW-1:0]            lookup_reg_i,
  output logic                     byp_hit_o,
  output logic [WIDTH-1:0]         byp_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] data_mem_q [DEPTH];
  logic [AW-1:0]    reg_mem_q  [DEPTH];
  logic [PW-1:0]    head_q, tail_q, head_d, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] wr_data_q;
  logic [AW-1:0]    wr_reg_q;
  logic             wr_en_q;

  logic [31:0]      word;
  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;
  logic [WIDTH-1:0] load_val, result;
  logic             store, push, pop;
  logic [PW-1:0]    idx;

  // Result select and load lane extraction
  always_comb begin
    word      = mem_data_i[31:0];
    byte_lane = word[8*addr_lo_i +: 8];
    half_lane = addr_lo_i[1] ? word[31:16] : word[15:0];
    unique case (size_i)
      2'b00: begin
        load_val       = {WIDTH{ld_signed_i & byte_lane[7]}};
        load_val[7:0]  = byte_lane;
      end
      2'b01: begin
        load_val       = {WIDTH{ld_signed_i & half_lane[15]}};
        load_val[15:0] = half_lane;
      end
      default: begin
        load_val       = {WIDTH{ld_signed_i & word[31]}};
        load_val[31:0] = word;
      end
    endcase
    unique case (md_i)
      2'b00:   result = f_out_i;
      2'b01:   result = load_val;
      2'b10:   result = WIDTH'(n_xor_v_i);
      default: result = link_i;
    endcase
  end

  assign in_ready_o = !reset_i && (count_q != CW'(DEPTH));
  assign store      = rw_i && !((ZERO_REG != 0) && (da_i == '0));
  assign push       = in_valid_i && in_ready_o && store;
  assign pop        = (count_q != '0) && rf_ready_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
    if (pop)  head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_data_q <= '0;
      wr_reg_q  <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wr_en_q <= pop;
      if (pop) begin
        wr_data_q <= data_mem_q[head_q];
        wr_reg_q  <= reg_mem_q[head_q];
      end
    end
  end

  // Entry storage needs no reset: occupancy is tracked by count_q alone
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem_q[tail_q] <= result;
      reg_mem_q[tail_q]  <= da_i;
    end
  end

  // Scan oldest to youngest so the youngest match overrides; output register is lowest
  always_comb begin
    byp_hit_o  = 1'b0;
    byp_data_o = '0;
    idx        = '0;
    if (wr_en_q && (wr_reg_q == lookup_reg_i)) begin
      byp_hit_o  = 1'b1;
      byp_data_o = wr_data_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = PW'((32'(head_q) + i) % DEPTH);
      if ((CW'(i) < count_q) && (reg_mem_q[idx] == lookup_reg_i)) begin
        byp_hit_o  = 1'b1;
        byp_data_o = data_mem_q[idx];
      end
    end
  end

  assign wr_data_o = wr_data_q;
  assign wr_reg_o  = wr_reg_q;
  assign wr_en_o   = wr_en_q;
  assign count_o   = count_q;

endmodule

// File: tb/tb_wb_retire_buffer.sv
// Scoreboard bench for wb_retire_buffer: a queue-based model predicts retired writes,
// occupancy and bypass results; a negedge monitor compares against the DUT.
module tb_wb_retire_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    bit        valid;
    bit [31:0] f, mem, link;
    bit [1:0]  lo, size, md;
    bit        sgn, nv, rw, rfr;
    bit [4:0]  da, lk;
    bit        use_exp;
    bit [31:0] exp;
  } vec_t;

  typedef struct {
    bit [4:0]  r;
    bit [31:0] d;
  } ent_t;

  logic        clk = 1'b0, reset = 1'b1;
  logic        in_valid, in_ready, ld_signed, n_xor_v, rw, rf_ready, wr_en, byp_hit;
  logic [31:0] f_out, mem_data, link, wr_data, byp_data;
  logic [1:0]  addr_lo, size, md;
  logic [4:0]  da, wr_reg, lookup_reg;
  logic [2:0]  count;

  int   n_vec = 0, n_err = 0;
  bit   mon_en = 0;
  vec_t cur;
  ent_t mq[$], exp_q[$];
  bit        ov = 0;
  bit [4:0]  oreg = '0;
  bit [31:0] odat = '0;

  wb_retire_buffer #(.WIDTH(32), .AW(5), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .f_out_i(f_out), .mem_data_i(mem_data), .addr_lo_i(addr_lo), .size_i(size),
    .ld_signed_i(ld_signed), .n_xor_v_i(n_xor_v), .link_i(link), .md_i(md), .da_i(da),
    .rw_i(rw), .rf_ready_i(rf_ready), .wr_data_o(wr_data), .wr_reg_o(wr_reg),
    .wr_en_o(wr_en), .lookup_reg_i(lookup_reg), .byp_hit_o(byp_hit), .byp_data_o(byp_data),
    .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] ref_result(vec_t v);
    longint unsigned x;
    case (v.md)
      2'd0: return v.f;
      2'd2: return {31'b0, v.nv};
      2'd3: return v.link;
      default: begin
        if (v.size == 2'd0) begin
          x = (64'(v.mem) >> (8 * v.lo)) & 64'hFF;
          if (v.sgn && x[7]) x = x | 64'hFFFF_FF00;
        end else if (v.size == 2'd1) begin
          x = (64'(v.mem) >> (16 * v.lo[1])) & 64'hFFFF;
          if (v.sgn && x[15]) x = x | 64'hFFFF_0000;
        end else begin
          x = 64'(v.mem);
        end
        return x[31:0];
      end
    endcase
  endfunction

  function automatic vec_t idle(bit rfr, bit [4:0] lk);
    vec_t v = '{default: '0};
    v.rfr = rfr;
    v.lk  = lk;
    return v;
  endfunction

  function automatic vec_t wr(bit [4:0] r, bit [31:0] val, bit rfr);
    vec_t v = idle(rfr, r);
    v.valid = 1; v.rw = 1; v.da = r; v.f = val; v.md = 2'd0;
    return v;
  endfunction

  task automatic drive_pins();
    in_valid = cur.valid; f_out = cur.f; mem_data = cur.mem; link = cur.link;
    addr_lo = cur.lo; size = cur.size; md = cur.md; ld_signed = cur.sgn;
    n_xor_v = cur.nv; rw = cur.rw; rf_ready = cur.rfr; da = cur.da; lookup_reg = cur.lk;
  endtask

  // Advance the model by one edge using the inputs currently on the pins, then drive v
  task automatic apply(vec_t v);
    bit   pop, acc;
    ent_t e;
    @(posedge clk);
    if (!reset) begin
      pop = cur.rfr && (mq.size() > 0);
      acc = cur.valid && (mq.size() != DEPTH);
      if (pop) begin
        e = mq.pop_front();
        exp_q.push_back(e);
        ov = 1; oreg = e.r; odat = e.d;
      end else begin
        ov = 0;
      end
      if (acc && cur.rw && cur.da != 0) begin
        e.r = cur.da;
        e.d = cur.use_exp ? cur.exp : ref_result(cur);
        mq.push_back(e);
      end
    end
    #2;
    cur = v;
    drive_pins();
  endtask

  // Monitor: compare registered outputs, occupancy and bypass against the model
  initial begin
    ent_t      e;
    bit        hit;
    bit [31:0] dat;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("count", count, mq.size());
        chk("in_ready", in_ready, (!reset && mq.size() != DEPTH));
        chk("wr_en", wr_en, ov);
        if (wr_en) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL wr_unexpected: got wr_en=1 reg=%0d expected no write", wr_reg);
          end else begin
            e = exp_q.pop_front();
            chk("wr_reg", wr_reg, e.r);
            chk("wr_data", wr_data, e.d);
          end
        end
        hit = 0; dat = 0;
        if (ov && oreg == cur.lk) begin hit = 1; dat = odat; end
        foreach (mq[i]) if (mq[i].r == cur.lk) begin hit = 1; dat = mq[i].d; end
        chk("byp_hit", byp_hit, hit);
        chk("byp_data", byp_data, dat);
      end
    end
  end

  initial begin
    vec_t v;
    cur = idle(0, 0);
    drive_pins();
    #1;
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_reg", wr_reg, 0);
    chk("rst_byp_hit", byp_hit, 0);
    @(negedge clk);
    reset  = 0;
    mon_en = 1;

    // Latency: single write, rf_ready held high
    apply(wr(5'd3, 32'h1234_5678, 1));
    repeat (3) apply(idle(1, 3));

    // Load extraction and flag select with known results
    v = wr(5'd7, 0, 1); v.md = 2'd1; v.mem = 32'h80FF_7F01; v.size = 0; v.lo = 2; v.sgn = 1;
    v.use_exp = 1; v.exp = 32'hFFFF_FFFF; apply(v);
    v.da = 8; v.lo = 0; v.sgn = 0; v.exp = 32'h0000_0001; apply(v);
    v.da = 9; v.size = 1; v.lo = 2; v.sgn = 1; v.exp = 32'hFFFF_80FF; apply(v);
    v.da = 10; v.md = 2'd2; v.nv = 1; v.exp = 32'h0000_0001; apply(v);
    repeat (3) apply(idle(1, 9));

    // Fill to DEPTH with drain stalled; the extra push must be refused
    for (int i = 1; i <= DEPTH + 1; i++) apply(wr(5'(i), 32'hC0DE_0000 + i, 0));
    apply(idle(0, 2));
    repeat (DEPTH + 2) apply(idle(1, 2));

    // Drops: register zero and rw=0
    apply(wr(5'd0, 32'hDEAD_0000, 1));
    v = wr(5'd4, 32'hDEAD_0004, 1); v.rw = 0; apply(v);
    repeat (2) apply(idle(1, 0));

    // Bypass: youngest of two writes to r5 wins, r6 misses
    apply(wr(5'd5, 32'hA, 0));
    apply(wr(5'd5, 32'hB, 0));
    apply(idle(0, 5));
    apply(idle(0, 6));
    repeat (4) apply(idle(1, 5));

    // Asynchronous reset mid-cycle with three entries pending
    for (int i = 0; i < 3; i++) apply(wr(5'(11 + i), 32'h5000 + i, 0));
    apply(idle(0, 11));
    #1;
    reset = 1;
    mq.delete(); exp_q.delete(); ov = 0;
    #1;
    chk("async_count", count, 0);
    chk("async_wr_en", wr_en, 0);
    chk("async_byp_hit", byp_hit, 0);
    chk("async_in_ready", in_ready, 0);
    @(negedge clk);
    #2 reset = 0;
    repeat (5) apply(idle(1, 11));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      v = '{default: '0};
      v.valid = ($urandom_range(0, 9) < 8);
      v.f = $urandom; v.mem = $urandom; v.link = $urandom;
      v.lo = 2'($urandom); v.size = 2'($urandom); v.md = 2'($urandom);
      v.sgn = 1'($urandom); v.nv = 1'($urandom); v.rw = ($urandom_range(0, 9) < 9);
      v.rfr = ($urandom_range(0, 9) < 6);
      v.da = 5'($urandom_range(0, 7)); v.lk = 5'($urandom_range(0, 7));
      apply(v);
    end

    repeat (DEPTH + 3) apply(idle(1, 0));
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("model_drained", count, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
